// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package memory_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } arb_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // One master's request as presented to the memory port.
  typedef struct packed {
    logic              command;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] write_mask;
  } mem_request_t;

  // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never narrower than one bit.
  function automatic int unsigned counter_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_select.sv
// Two-way round-robin selector.
//   req     : request vector, bit i = master i requesting
//   last    : index of the most recently granted master
//   grant_c : selected master index (combinational); a lone requester wins,
//             a tie goes to the master that was not granted last
module rr_select (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_c
);

  always_comb begin
    grant_c = ~last;
    case (req)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      default: grant_c = ~last;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one ready/valid memory port between master 0 (core) and master 1
// (debug/DMA loader). Round-robin grant, a single outstanding transaction and
// a response watchdog.
//   clk, reset (async, active low)
//   m{0,1}_*            : master request in, ready/valid/read_data out
//   memory_*            : memory-side handshake, request fields and read data
//   busy                : a transaction is outstanding
//   owner               : last/current granted master
//   timeout_error       : one-cycle pulse when the watchdog aborts a transaction
// Request path and response delivery are combinational (zero added latency);
// state, owner and watchdog counter are registered.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MASTER = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_enable,
  input  logic        m0_command,
  input  logic [31:0] m0_read_address,
  input  logic [31:0] m0_write_address,
  input  logic [31:0] m0_write_data,
  input  logic [31:0] m0_write_mask,
  output logic        m0_ready,
  output logic        m0_valid,
  output logic [31:0] m0_read_data,

  input  logic        m1_enable,
  input  logic        m1_command,
  input  logic [31:0] m1_read_address,
  input  logic [31:0] m1_write_address,
  input  logic [31:0] m1_write_data,
  input  logic [31:0] m1_write_mask,
  output logic        m1_ready,
  output logic        m1_valid,
  output logic [31:0] m1_read_data,

  input  logic        memory_ready,
  input  logic        memory_valid,
  input  logic [31:0] read_memory_data,
  output logic        memory_enable,
  output logic        memory_command_out,
  output logic [31:0] read_memory_address,
  output logic [31:0] write_memory_address,
  output logic [31:0] write_memory_data,
  output logic [31:0] write_memory_mask,

  output logic        busy,
  output logic        owner,
  output logic        timeout_error
);

  localparam int unsigned CNT_W        = counter_width(TIMEOUT_CYCLES);
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic WATCHDOG_ON = (TIMEOUT_CYCLES != 0);
  // Owner resets to the non-priority master so the first tie goes to PRIORITY_MASTER.
  localparam logic RESET_OWNER = (PRIORITY_MASTER == 0);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] count_q, count_d;

  mem_request_t req0, req1, mem_req;
  logic         sel;
  logic         sel_enable;
  logic         resp_valid;
  logic [31:0]  resp_data;

  assign req0 = '{command:       m0_command,
                  read_address:  m0_read_address,
                  write_address: m0_write_address,
                  write_data:    m0_write_data,
                  write_mask:    m0_write_mask};
  assign req1 = '{command:       m1_command,
                  read_address:  m1_read_address,
                  write_address: m1_write_address,
                  write_data:    m1_write_data,
                  write_mask:    m1_write_mask};

  rr_select u_rr_select (
    .req     ({m1_enable, m0_enable}),
    .last    (owner_q),
    .grant_c (sel)
  );

  // State, owner and watchdog counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= RESET_OWNER;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
    end
  end

  // Next state, request routing and response delivery.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    count_d       = count_q;
    mem_req       = '0;
    sel_enable    = 1'b0;
    memory_enable = 1'b0;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    timeout_error = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by reset so every request-side output reads 0 while reset is held.
        if (reset) begin
          mem_req       = sel ? req1 : req0;
          sel_enable    = sel ? m1_enable : m0_enable;
          memory_enable = sel_enable;
          if (sel_enable && memory_ready) begin
            m0_ready = ~sel;
            m1_ready = sel;
            owner_d  = sel;
            count_d  = '0;
            state_d  = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
        // A real response in the threshold cycle takes precedence over the abort.
        if (memory_valid) begin
          resp_valid = 1'b1;
          resp_data  = read_memory_data;
          state_d    = IDLE;
        end else if (WATCHDOG_ON && (count_q == CNT_LAST)) begin
          resp_valid    = 1'b1;
          timeout_error = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    m0_valid     = resp_valid && !owner_q;
    m1_valid     = resp_valid && owner_q;
    m0_read_data = m0_valid ? resp_data : '0;
    m1_read_data = m1_valid ? resp_data : '0;
  end

  assign memory_command_out   = mem_req.command;
  assign read_memory_address  = mem_req.read_address;
  assign write_memory_address = mem_req.write_address;
  assign write_memory_data    = mem_req.write_data;
  assign write_memory_mask    = mem_req.write_mask;

  assign busy  = (state_q == WAIT_RESP);
  assign owner = owner_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules.
module tb_memory_arbiter;

  localparam int PRI = 1;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  en;
  logic [1:0]  cmd;
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] wdata [2];
  logic [31:0] wmask [2];
  logic        memory_ready, memory_valid;
  logic [31:0] read_memory_data;

  logic        m0_ready, m0_valid, m1_ready, m1_valid;
  logic [31:0] m0_read_data, m1_read_data;
  logic        memory_enable, memory_command_out;
  logic [31:0] read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
  logic        busy, owner, timeout_error;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.PRIORITY_MASTER(PRI), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_enable(en[0]), .m0_command(cmd[0]), .m0_read_address(raddr[0]),
    .m0_write_address(waddr[0]), .m0_write_data(wdata[0]), .m0_write_mask(wmask[0]),
    .m0_ready(m0_ready), .m0_valid(m0_valid), .m0_read_data(m0_read_data),
    .m1_enable(en[1]), .m1_command(cmd[1]), .m1_read_address(raddr[1]),
    .m1_write_address(waddr[1]), .m1_write_data(wdata[1]), .m1_write_mask(wmask[1]),
    .m1_ready(m1_ready), .m1_valid(m1_valid), .m1_read_data(m1_read_data),
    .memory_ready(memory_ready), .memory_valid(memory_valid),
    .read_memory_data(read_memory_data), .memory_enable(memory_enable),
    .memory_command_out(memory_command_out), .read_memory_address(read_memory_address),
    .write_memory_address(write_memory_address), .write_memory_data(write_memory_data),
    .write_memory_mask(write_memory_mask),
    .busy(busy), .owner(owner), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 2'b00; cmd = 2'b00;
    for (int i = 0; i < 2; i++) begin
      raddr[i] = '0; waddr[i] = '0; wdata[i] = '0; wmask[i] = '0;
    end
    memory_ready = 1'b0; memory_valid = 1'b0; read_memory_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    #2;
    checks++;
    if ({memory_enable, m0_ready, m1_ready, m0_valid, m1_valid, timeout_error, busy, owner} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: flags=%b required=00000000", {memory_enable, m0_ready, m1_ready,
               m0_valid, m1_valid, timeout_error, busy, owner});
    end
    checks++;
    if ({m0_read_data, m1_read_data, read_memory_address, write_memory_data} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: rd0=%h rd1=%h raddr=%h wdata=%h required all zero",
               m0_read_data, m1_read_data, read_memory_address, write_memory_data);
    end
    tick();
    reset = 1'b1;
  endtask

  // Single read by m0, response three cycles after accept, then turnaround.
  task automatic test_single_read();
    apply_reset();
    en[0] = 1'b1; cmd[0] = 1'b0; raddr[0] = 32'h100; memory_ready = 1'b1;
    #2;
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || memory_enable !== 1'b1 ||
        read_memory_address !== 32'h100 || memory_command_out !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: m0_ready=%b m1_ready=%b en=%b addr=%h cmd=%b required 1 0 1 00000100 0",
               m0_ready, m1_ready, memory_enable, read_memory_address, memory_command_out);
    end
    tick();
    en[0] = 1'b0; memory_ready = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #2;
      checks++;
      if (busy !== 1'b1 || m0_valid !== 1'b0 || memory_enable !== 1'b0 || owner !== 1'b0) begin
        errors++;
        $display("FAIL single_wait%0d: busy=%b m0_valid=%b en=%b owner=%b required 1 0 0 0",
                 c, busy, m0_valid, memory_enable, owner);
      end
      tick();
    end
    // m0 re-requests in the response cycle: no accept allowed that cycle.
    memory_valid = 1'b1; read_memory_data = 32'hCAFEF00D;
    en[0] = 1'b1; memory_ready = 1'b1;
    #2;
    checks++;
    if (m0_valid !== 1'b1 || m0_read_data !== 32'hCAFEF00D || m1_valid !== 1'b0 ||
        m1_read_data !== 32'h0 || m0_ready !== 1'b0 || memory_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: m0_valid=%b rd0=%h m1_valid=%b rd1=%h m0_ready=%b en=%b required 1 cafef00d 0 0 0 0",
               m0_valid, m0_read_data, m1_valid, m1_read_data, m0_ready, memory_enable);
    end
    tick();
    memory_valid = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || m0_ready !== 1'b1 || m0_valid !== 1'b0) begin
      errors++;
      $display("FAIL turnaround_accept: busy=%b m0_ready=%b m0_valid=%b required 0 1 0",
               busy, m0_ready, m0_valid);
    end
    tick();
  endtask

  // Both masters always requesting, one-cycle memory: grants alternate, m1 first.
  task automatic test_round_robin();
    int g;
    apply_reset();
    en = 2'b11; cmd = 2'b00; raddr[0] = 32'hA0; raddr[1] = 32'hB0; memory_ready = 1'b1;
    g = 1;
    for (int k = 0; k < 6; k++) begin
      memory_valid = 1'b0;
      #2;
      checks++;
      if ({m1_ready, m0_ready} !== ((g == 1) ? 2'b10 : 2'b01) ||
          read_memory_address !== ((g == 1) ? 32'hB0 : 32'hA0)) begin
        errors++;
        $display("FAIL rr_grant%0d: ready{1,0}=%b addr=%h required master %0d", k,
                 {m1_ready, m0_ready}, read_memory_address, g);
      end
      tick();
      memory_valid = 1'b1; read_memory_data = 32'h1000 + 32'(k);
      #2;
      checks++;
      if ({m1_valid, m0_valid} !== ((g == 1) ? 2'b10 : 2'b01) ||
          ((g == 1) ? m1_read_data : m0_read_data) !== 32'h1000 + 32'(k) ||
          ((g == 1) ? m0_read_data : m1_read_data) !== 32'h0) begin
        errors++;
        $display("FAIL rr_resp%0d: valid{1,0}=%b rd0=%h rd1=%h required master %0d data %h",
                 k, {m1_valid, m0_valid}, m0_read_data, m1_read_data, g, 32'h1000 + 32'(k));
      end
      tick();
      g = 1 - g;
    end
  endtask

  // m1 write held against a stalled memory for four cycles, accepted on the fifth.
  task automatic test_stall();
    int hs;
    hs = 0;
    apply_reset();
    en[1] = 1'b1; cmd[1] = 1'b1; waddr[1] = 32'h200; wdata[1] = 32'h12345678;
    wmask[1] = 32'h0000FFFF; memory_ready = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      memory_ready = (c >= 5);
      if (c >= 6) en[1] = 1'b0;
      #2;
      if (memory_enable && memory_ready) hs++;
      if (c <= 4) begin
        checks++;
        if (memory_enable !== 1'b1 || m1_ready !== 1'b0 || m0_ready !== 1'b0 ||
            memory_command_out !== 1'b1 || write_memory_address !== 32'h200 ||
            write_memory_data !== 32'h12345678 || write_memory_mask !== 32'h0000FFFF) begin
          errors++;
          $display("FAIL stall_hold%0d: en=%b m1_ready=%b cmd=%b waddr=%h wdata=%h wmask=%h required 1 0 1 00000200 12345678 0000ffff",
                   c, memory_enable, m1_ready, memory_command_out, write_memory_address,
                   write_memory_data, write_memory_mask);
        end
      end else if (c == 5) begin
        checks++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_accept: m1_ready=%b m0_ready=%b required 1 0", m1_ready, m0_ready);
        end
      end
      tick();
    end
    checks++;
    if (hs !== 1) begin
      errors++;
      $display("FAIL stall_handshakes: count=%0d required 1", hs);
    end
  endtask

  // m0 read never answered: abort eight cycles after accept, late response ignored.
  task automatic test_timeout();
    apply_reset();
    en[0] = 1'b1; cmd[0] = 1'b0; raddr[0] = 32'h40; memory_ready = 1'b1;
    read_memory_data = 32'hDEADBEEF;
    #2;
    checks++;
    if (m0_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_accept: m0_ready=%b required 1", m0_ready);
    end
    tick();
    en[0] = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      #2;
      checks++;
      if (c < TMO) begin
        if ({m0_valid, m1_valid, timeout_error, busy} !== 4'b0001) begin
          errors++;
          $display("FAIL timeout_wait%0d: valid0=%b valid1=%b terr=%b busy=%b required 0 0 0 1",
                   c, m0_valid, m1_valid, timeout_error, busy);
        end
      end else begin
        if ({m0_valid, m1_valid, timeout_error} !== 3'b101 || m0_read_data !== 32'h0) begin
          errors++;
          $display("FAIL timeout_abort: valid0=%b valid1=%b terr=%b rd0=%h required 1 0 1 00000000",
                   m0_valid, m1_valid, timeout_error, m0_read_data);
        end
      end
      tick();
    end
    memory_valid = 1'b1; memory_ready = 1'b0;
    #2;
    checks++;
    if ({m0_valid, m1_valid, timeout_error, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_late_resp: valid0=%b valid1=%b terr=%b busy=%b required 0 0 0 0",
               m0_valid, m1_valid, timeout_error, busy);
    end
    tick();
    memory_valid = 1'b0;
  endtask

  // Reset during WAIT_RESP clears busy immediately; next m1 request works.
  task automatic test_reset_mid();
    apply_reset();
    en[0] = 1'b1; raddr[0] = 32'h300; memory_ready = 1'b1;
    tick();
    en[0] = 1'b0; memory_ready = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy_before: busy=%b required 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || memory_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: busy=%b en=%b required 0 0", busy, memory_enable);
    end
    tick();
    tick();
    reset = 1'b1;
    en[1] = 1'b1; cmd[1] = 1'b1; waddr[1] = 32'h404; wdata[1] = 32'h55; wmask[1] = 32'hFF;
    memory_ready = 1'b1;
    #2;
    checks++;
    if (m1_ready !== 1'b1 || write_memory_address !== 32'h404) begin
      errors++;
      $display("FAIL reset_mid_reaccept: m1_ready=%b waddr=%h required 1 00000404",
               m1_ready, write_memory_address);
    end
    tick();
    en[1] = 1'b0; memory_valid = 1'b1; read_memory_data = 32'h77;
    #2;
    checks++;
    if (m1_valid !== 1'b1 || m0_valid !== 1'b0 || owner !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_resp: m1_valid=%b m0_valid=%b owner=%b required 1 0 1",
               m1_valid, m0_valid, owner);
    end
    tick();
    memory_valid = 1'b0;
  endtask

  // Response arriving exactly at the watchdog threshold wins.
  task automatic test_valid_at_threshold();
    apply_reset();
    en[1] = 1'b1; cmd[1] = 1'b0; raddr[1] = 32'h600; memory_ready = 1'b1;
    tick();
    en[1] = 1'b0; memory_ready = 1'b0;
    for (int c = 1; c < TMO; c++) tick();
    memory_valid = 1'b1; read_memory_data = 32'h5A5A1234;
    #2;
    checks++;
    if (m1_valid !== 1'b1 || m1_read_data !== 32'h5A5A1234 || timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL threshold_resp: m1_valid=%b rd1=%h terr=%b required 1 5a5a1234 0",
               m1_valid, m1_read_data, timeout_error);
    end
    tick();
    memory_valid = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || m1_valid !== 1'b0) begin
      errors++;
      $display("FAIL threshold_after: busy=%b m1_valid=%b required 0 0", busy, m1_valid);
    end
    tick();
  endtask

  // Random traffic against a transaction-level model.
  task automatic test_random();
    bit          pend [2];
    bit          mdl_busy;
    int          mdl_owner;
    int          mdl_wait;
    int          sel;
    int          vld_pct;
    bit          e_en, e_tmo;
    bit [1:0]    e_rdy, e_vld;
    logic [31:0] e_rd [2];
    logic [7:0]  got, exp;
    apply_reset();
    pend[0] = 0; pend[1] = 0;
    mdl_busy = 0; mdl_owner = 1 - PRI; mdl_wait = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1;
          cmd[i] = 1'($urandom);
          raddr[i] = $urandom; waddr[i] = $urandom; wdata[i] = $urandom; wmask[i] = $urandom;
        end
      end
      en = {pend[1], pend[0]};
      vld_pct = (n < 300) ? 25 : 6;
      memory_ready = ($urandom_range(0, 99) < 70);
      memory_valid = ($urandom_range(0, 99) < vld_pct);
      read_memory_data = $urandom;
      #2;
      // Expected behaviour this cycle.
      e_en = 0; e_tmo = 0; e_rdy = 2'b00; e_vld = 2'b00; e_rd[0] = '0; e_rd[1] = '0; sel = -1;
      if (!mdl_busy) begin
        if (en == 2'b11) sel = 1 - mdl_owner;
        else if (en[1]) sel = 1;
        else if (en[0]) sel = 0;
        e_en = (sel >= 0);
        if (e_en && memory_ready) e_rdy[sel] = 1'b1;
      end else if (memory_valid) begin
        e_vld[mdl_owner] = 1'b1; e_rd[mdl_owner] = read_memory_data;
      end else if (mdl_wait == TMO) begin
        e_vld[mdl_owner] = 1'b1; e_tmo = 1;
      end
      got = {memory_enable, m1_ready, m0_ready, m1_valid, m0_valid, timeout_error, busy, owner};
      exp = {e_en, e_rdy, e_vld, e_tmo, mdl_busy, 1'(mdl_owner)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_flags cyc %0d: {en,rdy1,rdy0,vld1,vld0,terr,busy,owner}=%b required %b",
                 n, got, exp);
      end
      checks++;
      if (m0_read_data !== e_rd[0] || m1_read_data !== e_rd[1]) begin
        errors++;
        $display("FAIL rand_rdata cyc %0d: rd0=%h rd1=%h required %h %h",
                 n, m0_read_data, m1_read_data, e_rd[0], e_rd[1]);
      end
      if (sel >= 0) begin
        checks++;
        if ({memory_command_out, read_memory_address, write_memory_address, write_memory_data,
             write_memory_mask} !== {cmd[sel], raddr[sel], waddr[sel], wdata[sel], wmask[sel]}) begin
          errors++;
          $display("FAIL rand_fields cyc %0d: cmd=%b ra=%h wa=%h wd=%h wm=%h required master %0d cmd=%b ra=%h wa=%h wd=%h wm=%h",
                   n, memory_command_out, read_memory_address, write_memory_address,
                   write_memory_data, write_memory_mask, sel, cmd[sel], raddr[sel], waddr[sel],
                   wdata[sel], wmask[sel]);
        end
      end
      // Advance the model at the clock edge.
      if (!mdl_busy) begin
        if (sel >= 0 && memory_ready) begin
          mdl_busy = 1; mdl_owner = sel; mdl_wait = 1; pend[sel] = 0;
        end
      end else if (memory_valid || mdl_wait == TMO) begin
        mdl_busy = 0;
      end else begin
        mdl_wait++;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_valid_at_threshold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
